inst_ram_loader: RTL and testbench

- Byte-stream writer that fills the instruction memory before the CPU runs; it is the write-side counterpart of the fetch-side read port.
- Receives a length-prefixed, big-endian byte stream and packs each 4 bytes into a 32-bit instruction word.
- Writes each word to instruction RAM with a ce/we/addr/data port and holds the CPU until loading completes.
- Sits between the host byte link (UART receiver or testbench) and the instruction RAM write port.

---
 rtl/inst_ram_loader.sv | 165 ++++++++++++++++
 tb/tb_inst_ram_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_loader.sv
// -----------------------------------------------------------------------------
// inst_ram_loader
//
// Fills instruction RAM from a length-prefixed, big-endian byte stream before
// the CPU is released. The stream is a 4-byte word count N followed by N
// 4-byte instruction words, all MSB first. Each assembled word is written to
// RAM in a single one-cycle WRITE beat at ADDR_BASE + 4*i. The CPU is held
// until the whole image has been written.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous, active-low reset
//   start     single-cycle pulse; begins a load from IDLE, DONE or ERR
//   rx_data   incoming stream byte
//   rx_valid  rx_data valid this cycle
//   rx_ready  loader accepts a byte this cycle (transfer = valid & ready)
//   mem_ce    RAM chip enable, high only during a write beat
//   mem_we    RAM write enable, high only during a write beat
//   mem_addr  RAM byte address (word aligned), holds outside write beats
//   mem_data  word being written, holds outside write beats
//   cpu_hold  keeps the CPU stalled while high
//   done      level: image loaded successfully, cleared by next start
//   err       level: word count exceeded MEM_WORDS, cleared by next start
// -----------------------------------------------------------------------------
module inst_ram_loader #(
    parameter int unsigned MEM_WORDS = 131071,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;      // the three most recent bytes of the current word
    logic [31:0] count_q;      // N, the number of words in the image
    logic [31:0] idx_q;        // index of the word being assembled/written
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;

    logic        byte_fire;
    logic        last_byte;
    logic [31:0] assembled;
    logic        last_word;

    assign byte_fire = rx_valid && rx_ready;
    assign last_byte = byte_fire && (byte_cnt_q == 2'd3);
    // Valid only together with last_byte: the fourth byte completes the word.
    assign assembled = {shift_q, rx_data};
    assign last_word = ((idx_q + 32'd1) == count_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch
        // is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (last_byte) begin
                    if (assembled == 32'd0)             state_d = S_DONE;
                    else if (assembled > MEM_WORDS_W)   state_d = S_ERR;
                    else                                state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: byte packing, word count, index and write-port registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            count_q    <= 32'd0;
            idx_q      <= 32'd0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
        end else begin
            // A new load always starts on a word boundary.
            if (start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR)) begin
                byte_cnt_q <= 2'd0;
            end else if (byte_fire) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= assembled[23:0];
            end

            if (state_q == S_LEN && last_byte) begin
                count_q <= assembled;
                idx_q   <= 32'd0;
            end

            // Capture address and word one cycle ahead so they are stable
            // registers throughout the write beat and hold afterwards.
            if (state_q == S_DATA && last_byte) begin
                mem_addr_q <= ADDR_BASE + {idx_q[29:0], 2'b00};
                mem_data_q <= assembled;
            end

            if (state_q == S_WRITE && !last_word) begin
                idx_q <= idx_q + 32'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from state so reset values appear immediately)
    // -------------------------------------------------------------------------
    assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
    assign mem_ce   = (state_q == S_WRITE);
    assign mem_we   = (state_q == S_WRITE);
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);

endmodule

// File: tb/tb_inst_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_ram_loader
//
// Two loader instances share one stimulus stream: dut0 with the default depth
// at base 0, dut1 with a depth of 4 words at base 0x100, so the same image
// exercises both the address base and the word-count limit. Expected writes
// and final status come from a reference model of the image format.
// -----------------------------------------------------------------------------
module tb_inst_ram_loader;

    localparam int unsigned MW0 = 131071;
    localparam int unsigned MW1 = 4;
    localparam logic [31:0] B0  = 32'h0000_0000;
    localparam logic [31:0] B1  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rx_ready0, mem_ce0, mem_we0, cpu_hold0, done0, err0;
    logic [31:0] mem_addr0, mem_data0;
    logic        rx_ready1, mem_ce1, mem_we1, cpu_hold1, done1, err1;
    logic [31:0] mem_addr1, mem_data1;

    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    logic [31:0] preset[$];

    always #5 clk = ~clk;

    inst_ram_loader #(.MEM_WORDS(MW0), .ADDR_BASE(B0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready0), .mem_ce(mem_ce0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .cpu_hold(cpu_hold0), .done(done0), .err(err0)
    );

    inst_ram_loader #(.MEM_WORDS(MW1), .ADDR_BASE(B1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready1), .mem_ce(mem_ce1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write and transfer monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we0) wq0.push_back({mem_addr0, mem_data0});
        if (mem_we1) wq1.push_back({mem_addr1, mem_data1});
        if (mem_ce0 || mem_we0) check("ce_we0", 64'(mem_ce0), 64'(mem_we0));
        if (mem_ce1 || mem_we1) check("ce_we1", 64'(mem_ce1), 64'(mem_we1));
        if (rx_valid && rx_ready0) xfers++;
    end

    // ---------------- reference model ----------------
    // status = {done, err, cpu_hold} after the load has settled
    function automatic logic [2:0] exp_status(input logic [31:0] n, input int unsigned mw);
        if (n > 32'(mw)) return 3'b011;
        return 3'b100;
    endfunction

    function automatic int exp_nwrites(input logic [31:0] n, input int unsigned mw);
        if (n > 32'(mw)) return 0;
        return int'(n);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 16 && !ok; t++) begin
            @(negedge clk);
            ok = rx_ready0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Load an image of n words; words come from preset, then random fill.
    task automatic do_load(input logic [31:0] n, input bit gaps, input bit mid_start,
                           input bit junk_write);
        logic [31:0] words[$];
        int          nw0;
        int          nw1;
        nw0 = exp_nwrites(n, MW0);
        nw1 = exp_nwrites(n, MW1);
        for (int i = 0; i < nw0; i++)
            words.push_back(i < preset.size() ? preset[i] : $urandom);
        wq0.delete();
        wq1.delete();
        xfers = 0;

        pulse_start();
        @(negedge clk);
        check("start_state", 64'({cpu_hold0, done0, err0, rx_ready0}), 64'(4'b1001));
        @(posedge clk); #1;

        for (int k = 3; k >= 0; k--) send_byte(n[8*k +: 8], gaps);

        for (int i = 0; i < nw0; i++) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(words[i][8*k +: 8], gaps);
                if (mid_start && i == 0 && k == 3) pulse_start();
            end
            if (junk_write) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
            end
            @(negedge clk);
            check("write_beat", 64'({mem_we0, rx_ready0}), 64'(2'b10));
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end

        // Status is due the cycle after the last write (or after the count).
        @(negedge clk);
        check("status0", 64'({done0, err0, cpu_hold0}), 64'(exp_status(n, MW0)));
        check("status1", 64'({done1, err1, cpu_hold1}), 64'(exp_status(n, MW1)));
        check("xfers", 64'(xfers), 64'(4 + 4 * nw0));
        check("nwrites0", 64'(wq0.size()), 64'(nw0));
        check("nwrites1", 64'(wq1.size()), 64'(nw1));
        for (int i = 0; i < nw0 && i < wq0.size(); i++)
            check("write0", wq0[i], {B0 + 32'(i) * 32'd4, words[i]});
        for (int i = 0; i < nw1 && i < wq1.size(); i++)
            check("write1", wq1[i], {B1 + 32'(i) * 32'd4, words[i]});
        @(posedge clk); #1;
        preset.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_ctl0", 64'({rx_ready0, mem_ce0, mem_we0, done0, err0, cpu_hold0}), 64'(6'b000001));
        check("rst_ctl1", 64'({rx_ready1, mem_ce1, mem_we1, done1, err1, cpu_hold1}), 64'(6'b000001));
        check("rst_bus0", {mem_addr0, mem_data0}, 64'd0);
        check("rst_bus1", {mem_addr1, mem_data1}, 64'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Two-word image at one byte per cycle.
        preset = {32'h3C01_0000, 32'h3421_0020};
        do_load(32'd2, 1'b0, 1'b0, 1'b0);

        // Same image with random gaps and bytes offered during write beats.
        preset = {32'h3C01_0000, 32'h3421_0020};
        do_load(32'd2, 1'b1, 1'b0, 1'b1);

        // Count boundaries.
        do_load(32'(MW0) + 32'd1, 1'b0, 1'b0, 1'b0);
        do_load(32'd0, 1'b0, 1'b0, 1'b0);

        // Restart from DONE, all-ones word.
        preset = {32'hFFFF_FFFF};
        do_load(32'd1, 1'b0, 1'b0, 1'b0);

        // Three words with an ignored start pulse mid-load.
        do_load(32'd3, 1'b1, 1'b1, 1'b0);
        do_load(32'd4, 1'b0, 1'b0, 1'b1);
        do_load(32'd5, 1'b1, 1'b0, 1'b0);

        // Reset in DATA after two bytes of a word.
        pulse_start();
        for (int k = 3; k >= 0; k--) send_byte(k == 0 ? 8'h01 : 8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        preset = {32'h3402_0001};
        do_load(32'd1, 1'b0, 1'b0, 1'b0);

        // Randomized images.
        for (int r = 0; r < 12; r++) begin
            do_load(32'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
